universal_shift_register_seq: RTL and testbench

//   Parametrised universal shift register with a multi-step shift sequencer.
//   A single start command selects an operation and a shift amount. The block

---
 rtl/universal_shift_register_seq.sv | 106 ++++++++++
 tb/tb_universal_shift_register_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register_seq.sv
// Universal N-bit shift register with a sequencer that performs a commanded
// number of one-bit shift/rotate steps, one per clock, reporting busy/done.
module universal_shift_register_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    mode,
    input  logic [CW-1:0] amount,
    input  logic          sin_msb,
    input  logic          sin_lsb,
    input  logic [N-1:0]  wData,
    output logic [N-1:0]  q,
    output logic          sout_msb,
    output logic          sout_lsb,
    output logic          busy,
    output logic          done,
    output logic          fsm_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_ASR  = 3'b101;
    localparam logic [2:0] M_LOAD = 3'b110;

    state_t        state;
    logic [2:0]    mode_r;
    logic [CW-1:0] cnt;
    logic          is_shift;

    // Handshake: start is a request that is taken at a rising edge only while
    // busy is low; busy low is the ready indication, and requests seen while
    // busy is high are dropped, never queued.
    assign is_shift  = (mode >= M_SHR) && (mode <= M_ASR);
    assign sout_msb  = q[N-1];
    assign sout_lsb  = q[0];
    assign fsm_state = state;

    function automatic logic [N-1:0] step_once(
        input logic [2:0]   m,
        input logic [N-1:0] v,
        input logic         sm,
        input logic         sl
    );
        case (m)
            M_SHR:   step_once = {sm, v[N-1:1]};
            M_SHL:   step_once = {v[N-2:0], sl};
            M_ROR:   step_once = {v[0], v[N-1:1]};
            M_ROL:   step_once = {v[N-2:0], v[N-1]};
            M_ASR:   step_once = {v[N-1], v[N-1:1]};
            default: step_once = v;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            q      <= '0;
            mode_r <= M_HOLD;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (mode == M_LOAD) begin
                            q    <= wData;
                            done <= 1'b1;
                        end else if (is_shift && (amount != '0)) begin
                            mode_r <= mode;
                            cnt    <= amount;
                            busy   <= 1'b1;
                            state  <= RUN;
                        end else begin
                            // hold, reserved and zero-length shifts finish at once
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q   <= step_once(mode_r, q, sin_msb, sin_lsb);
                    cnt <= cnt - 1'b1;
                    if (cnt == {{(CW-1){1'b0}}, 1'b1}) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_universal_shift_register_seq.sv
// Bench for universal_shift_register_seq: directed vector table, hand-written
// corner sequences, and random commands checked against an arithmetic model.
module tb_universal_shift_register_seq;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] amount;
    logic          sin_msb;
    logic          sin_lsb;
    logic [N-1:0]  wData;
    logic [N-1:0]  q;
    logic          sout_msb;
    logic          sout_lsb;
    logic          busy;
    logic          done;
    logic          fsm_state;

    int errors = 0;
    int checks = 0;
    logic [N-1:0] model_q;
    logic [N-1:0] exp_q[$];

    universal_shift_register_seq #(.N(N), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amount(amount),
        .sin_msb(sin_msb), .sin_lsb(sin_lsb), .wData(wData), .q(q),
        .sout_msb(sout_msb), .sout_lsb(sout_lsb), .busy(busy), .done(done),
        .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    m;
        logic [CW-1:0] a;
        logic [N-1:0]  d;
        logic [15:0]   mb;
        logic [15:0]   lb;
        logic [N-1:0]  exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Result of a whole command from the rules: rotates and ASR in closed form,
    // serial shifts by feeding the serial bit stream in order.
    function automatic logic [N-1:0] ref_result(input logic [2:0] m, input int a,
            input logic [N-1:0] q0, input logic [N-1:0] d,
            input logic [15:0] mb, input logic [15:0] lb);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   v;
        int r;
        r   = a % N;
        dbl = {q0, q0};
        v   = q0;
        case (m)
            3'd6: v = d;
            3'd1: for (int i = 0; i < a; i++) v = (v >> 1) | (N'(mb[i]) << (N-1));
            3'd2: for (int i = 0; i < a; i++) v = (v << 1) | N'(lb[i]);
            3'd3: begin dbl = dbl >> r; v = dbl[N-1:0]; end
            3'd4: begin dbl = dbl << r; v = dbl[2*N-1:N]; end
            3'd5: v = N'($signed(q0) >>> a);
            default: v = q0;
        endcase
        return v;
    endfunction

    // driver: called at a falling edge; issues a command and follows it to done
    task automatic run_cmd(input logic [2:0] m, input logic [CW-1:0] a, input logic [N-1:0] d,
            input logic [15:0] mb, input logic [15:0] lb, input logic [N-1:0] exp,
            input string name, input bit settle);
        logic [N-1:0] cur;
        bit multi;
        multi = (m >= 3'd1) && (m <= 3'd5) && (a != 0);
        cur = model_q;
        exp_q.push_back(exp);
        start = 1'b1; mode = m; amount = a; wData = d;
        @(negedge clk);
        start = 1'b0;
        mode = 3'($urandom); amount = CW'($urandom); wData = N'($urandom);
        if (multi) begin
            check({name, " busy_at_accept"}, {busy, done}, 2'b10);
            check({name, " q_at_accept"}, q, cur);
            for (int i = 0; i < int'(a); i++) begin
                sin_msb = mb[i];
                sin_lsb = lb[i];
                cur = ref_result(m, 1, cur, '0, {15'd0, mb[i]}, {15'd0, lb[i]});
                @(negedge clk);
                if (i < int'(a) - 1) begin
                    check({name, " busy_mid"}, {busy, done}, 2'b10);
                    check({name, " q_mid"}, {sout_msb, sout_lsb, q}, {cur[N-1], cur[0], cur});
                end
                mode = 3'($urandom); amount = CW'($urandom); wData = N'($urandom);
            end
        end
        check({name, " done_pulse"}, {busy, done}, 2'b01);
        check({name, " q_final"}, q, exp_q.pop_front());
        model_q = exp;
        if (settle) begin
            @(negedge clk);
            check({name, " done_clear"}, {busy, done, q}, {2'b00, exp});
        end
    endtask

    vec_t vecs[15];

    initial begin
        logic [2:0]    rm;
        logic [CW-1:0] ra;
        logic [N-1:0]  rd;
        logic [15:0]   rmb, rlb;
        bit saw_done;

        vecs[0]  = '{3'd6, 4'd0,  8'h81, 16'h0, 16'h0, 8'h81};
        vecs[1]  = '{3'd3, 4'd3,  8'h00, 16'h0, 16'h0, 8'h30};
        vecs[2]  = '{3'd6, 4'd0,  8'h81, 16'h0, 16'h0, 8'h81};
        vecs[3]  = '{3'd4, 4'd9,  8'h00, 16'h0, 16'h0, 8'h03};
        vecs[4]  = '{3'd6, 4'd0,  8'h90, 16'h0, 16'h0, 8'h90};
        vecs[5]  = '{3'd5, 4'd2,  8'h00, 16'h0, 16'h0, 8'hE4};
        vecs[6]  = '{3'd5, 4'd15, 8'h00, 16'h0, 16'h0, 8'hFF};
        vecs[7]  = '{3'd6, 4'd0,  8'h00, 16'h0, 16'h0, 8'h00};
        vecs[8]  = '{3'd1, 4'd4,  8'h00, 16'hD, 16'h0, 8'hD0};
        vecs[9]  = '{3'd2, 4'd0,  8'h00, 16'h0, 16'h0, 8'hD0};
        vecs[10] = '{3'd7, 4'd5,  8'hFF, 16'h0, 16'h0, 8'hD0};
        vecs[11] = '{3'd0, 4'd3,  8'hFF, 16'h0, 16'h0, 8'hD0};
        vecs[12] = '{3'd2, 4'd3,  8'h00, 16'h0, 16'h3, 8'h86};
        vecs[13] = '{3'd6, 4'd0,  8'hA5, 16'h0, 16'h0, 8'hA5};
        vecs[14] = '{3'd1, 4'd10, 8'h00, 16'h0, 16'h0, 8'h00};

        rst = 1'b0; start = 1'b0; mode = '0; amount = '0;
        sin_msb = 1'b0; sin_lsb = 1'b0; wData = '0;
        model_q = '0;
        repeat (3) @(negedge clk);
        check("reset_state", {q, busy, done, fsm_state}, {8'h00, 3'b000});
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++)
            run_cmd(vecs[i].m, vecs[i].a, vecs[i].d, vecs[i].mb, vecs[i].lb,
                    vecs[i].exp, $sformatf("vec%0d", i), 1'b1);

        // reset in the middle of a SHL 5, after two steps
        run_cmd(3'd6, 4'd0, 8'h0F, 16'h0, 16'h0, 8'h0F, "rst_load", 1'b1);
        start = 1'b1; mode = 3'd2; amount = 4'd5; sin_lsb = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pre_abort_q", q, 8'h3F);
        rst = 1'b0;
        #1;
        check("rst_async", {q, busy, done, fsm_state}, {8'h00, 3'b000});
        @(negedge clk);
        rst = 1'b1;
        model_q = '0;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_no_done", saw_done, 1'b0);
        run_cmd(3'd6, 4'd0, 8'hA5, 16'h0, 16'h0, 8'hA5, "rst_reload", 1'b1);

        // start while busy is ignored; start in the done cycle is taken
        run_cmd(3'd6, 4'd0, 8'h3C, 16'h0, 16'h0, 8'h3C, "busy_load", 1'b1);
        start = 1'b1; mode = 3'd1; amount = 4'd6; sin_msb = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            start = (i == 2);
            mode = 3'd6; wData = 8'hFF;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_ignore_done", {busy, done}, 2'b01);
        check("busy_ignore_q", q, 8'hFC);
        model_q = 8'hFC;
        run_cmd(3'd6, 4'd0, 8'h5A, 16'h0, 16'h0, 8'h5A, "back_to_back", 1'b1);

        // random commands against the reference model
        for (int n = 0; n < 40; n++) begin
            rm  = 3'($urandom_range(0, 7));
            ra  = CW'($urandom_range(0, 15));
            rd  = N'($urandom);
            rmb = 16'($urandom);
            rlb = 16'($urandom);
            run_cmd(rm, ra, rd, rmb, rlb, ref_result(rm, int'(ra), model_q, rd, rmb, rlb),
                    $sformatf("rand%0d", n), n[0]);
        end

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
